// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display data/control in (en, load, bcd_in, dp_in, blank_in, blink_in, lz_suppress) and pin outputs (seg, dp, an, scan_idx)
interface seg7_scan_if #(parameter int DIGITS = 4);
  logic en, load, lz_suppress, dp;
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0] dp_in, blank_in, blink_in, an;
  logic [6:0] seg;
  logic [$clog2(DIGITS)-1:0] scan_idx;
  modport master(output en, load, lz_suppress, bcd_in, dp_in, blank_in, blink_in, input seg, dp, an, scan_idx);
  modport slave(input en, load, lz_suppress, bcd_in, dp_in, blank_in, blink_in, output seg, dp, an, scan_idx);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex 7-seg scanner with dp/blank/blink/lz-suppress; ports clk, rst_n (async low), bus (seg7_scan_if.slave)
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD = 1,
  parameter int BLINK_DIV = 500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [15:0][6:0] LUT = {7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
                                      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};
  logic [4*DIGITS-1:0] held_bcd;
  logic [DIGITS-1:0] held_dp, held_blank, held_blink, sup, an_on, an_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic phase, zero_above, dark, dp_on, dp_q, wrap, bwrap, guard;
  logic [3:0] digit;
  logic [6:0] pat, seg_q;
  always_comb begin
    sup = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      sup[i] = bus.lz_suppress && zero_above && held_bcd[4*i +: 4] == 4'd0;
      zero_above = zero_above && (held_bcd[4*i +: 4] == 4'd0 || held_blank[i]);
    end
  end
  always_comb begin
    digit = held_bcd[4*idx +: 4];
    dark = held_blank[idx] || (held_blink[idx] && phase) || sup[idx];
    pat = dark ? 7'h00 : LUT[digit];
    dp_on = !dark && held_dp[idx];
    guard = 32'(cnt) < GUARD;
    an_on = guard ? '0 : DIGITS'(1) << idx;
    wrap = cnt == CW'(REFRESH_DIV - 1);
    bwrap = bcnt == BW'(BLINK_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_bcd <= '0;
      held_dp <= '0;
      held_blank <= '0;
      held_blink <= '0;
      cnt <= '0;
      idx <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      seg_q <= SEG_OFF;
      dp_q <= SEG_ACTIVE_LOW;
      an_q <= AN_OFF;
    end else begin
      if (bus.load) begin
        held_bcd <= bus.bcd_in;
        held_dp <= bus.dp_in;
        held_blank <= bus.blank_in;
        held_blink <= bus.blink_in;
      end
      bcnt <= bwrap ? '0 : bcnt + 1'b1;
      phase <= phase ^ bwrap;
      cnt <= (!bus.en || wrap) ? '0 : cnt + 1'b1;
      idx <= !bus.en ? '0 : !wrap ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      seg_q <= bus.en ? pat ^ SEG_OFF : SEG_OFF;
      dp_q <= bus.en ? dp_on ^ SEG_ACTIVE_LOW : SEG_ACTIVE_LOW;
      an_q <= bus.en ? an_on ^ AN_OFF : AN_OFF;
    end
  end
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
  assign bus.scan_idx = idx;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, blink every 16)
module tb_seg7_scan_driver;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic [1:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  string label = "init";
  always #5 clk = ~clk;
  seg7_scan_if #(.DIGITS(4)) bus();
  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .BLINK_DIV(16),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got an=%h seg=%h dp=%b idx=%0d, expected an=%h seg=%h dp=%b idx=%0d",
               name, act[13:10], act[9:3], act[2], act[1:0], exp[13:10], exp[9:3], exp[2], exp[1:0]);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(label, {bus.an, bus.seg, bus.dp, bus.scan_idx}, e);
    end
  end
  task automatic push(input logic [3:0] an, input logic [6:0] pat, input logic dp_on, input logic [1:0] idx);
    q.push_back('{an: an, seg: ~pat, dp: ~dp_on, idx: idx});
  endtask
  task automatic slot(input logic [1:0] d, input logic [6:0] pat, input logic dp_on);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    push(4'hF, pat, dp_on, d);
    push(a, pat, dp_on, d);
    push(a, pat, dp_on, d);
    push(a, pat, dp_on, d + 2'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d expected outputs pending, required 0", label, q.size());
      q.delete();
    end
  endtask
  task automatic restart(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz, input string name);
    repeat (2) @(negedge clk);
    label = name;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.load = 1'b0;
    #1;
    chk({name, " reset"}, {bus.an, bus.seg, bus.dp, bus.scan_idx}, {4'hF, 7'h7F, 1'b1, 2'd0});
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1'b1;
    bus.bcd_in = v;
    bus.dp_in = dpv;
    bus.blank_in = bl;
    bus.blink_in = bk;
    bus.lz_suppress = lz;
    @(negedge clk);
    bus.load = 1'b0;
    bus.en = 1'b1;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.lz_suppress = 1'b0;
    bus.bcd_in = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    bus.blink_in = '0;
    restart(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, "scan");
    slot(0, 7'h33, 0); slot(1, 7'h79, 0); slot(2, 7'h6D, 0); slot(3, 7'h30, 0); slot(0, 7'h33, 0);
    drain();
    restart(16'hABCD, 4'b0000, 4'b0000, 4'b0000, 1'b0, "hex");
    slot(0, 7'h3D, 0); slot(1, 7'h4E, 0); slot(2, 7'h1F, 0); slot(3, 7'h77, 0);
    drain();
    restart(16'h0050, 4'b1010, 4'b0000, 4'b0000, 1'b1, "lz_0050");
    slot(0, 7'h7E, 0); slot(1, 7'h5B, 1); slot(2, 7'h00, 0); slot(3, 7'h00, 0);
    drain();
    restart(16'h0700, 4'b0000, 4'b0100, 4'b0000, 1'b1, "lz_blank_above");
    slot(0, 7'h7E, 0); slot(1, 7'h00, 0); slot(2, 7'h00, 0); slot(3, 7'h00, 0);
    drain();
    restart(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, "lz_0000");
    slot(0, 7'h7E, 0); slot(1, 7'h00, 0); slot(2, 7'h00, 0); slot(3, 7'h00, 0);
    drain();
    label = "lz_off";
    bus.lz_suppress = 1'b0;
    slot(0, 7'h7E, 0); slot(1, 7'h7E, 0); slot(2, 7'h7E, 0); slot(3, 7'h7E, 0);
    drain();
    restart(16'h1234, 4'b0000, 4'b0100, 4'b0001, 1'b0, "blink_blank");
    slot(0, 7'h33, 0); slot(1, 7'h79, 0); slot(2, 7'h00, 0); slot(3, 7'h30, 0);
    slot(0, 7'h00, 0); slot(1, 7'h79, 0); slot(2, 7'h00, 0); slot(3, 7'h30, 0);
    slot(0, 7'h33, 0);
    drain();
    restart(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, "en_drop");
    slot(0, 7'h33, 0);
    push(4'hF, 7'h79, 0, 1);
    push(4'hD, 7'h79, 0, 1);
    drain();
    bus.en = 1'b0;
    repeat (10) push(4'hF, 7'h00, 0, 0);
    drain();
    label = "en_resume";
    bus.en = 1'b1;
    slot(0, 7'h33, 0); slot(1, 7'h79, 0);
    drain();
    restart(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, "load_at_slot");
    slot(0, 7'h33, 0);
    push(4'hF, 7'h79, 0, 1);
    push(4'hD, 7'h79, 0, 1);
    push(4'hD, 7'h79, 0, 1);
    drain();
    bus.bcd_in = 16'h5678;
    bus.load = 1'b1;
    push(4'hD, 7'h79, 0, 2);
    slot(2, 7'h5F, 0); slot(3, 7'h5B, 0);
    @(negedge clk);
    bus.load = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Captures a packed 4-bit-per-digit value on a load strobe and scans the digits round-robin at a parameterised refresh rate.
- Decodes hex 0-F per digit, with per-digit decimal point, blanking and blink, plus leading-zero suppression.
- Sits between the time/alarm datapath and the board display pins.

Parameters:
- DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 1000: clk cycles per digit slot (>= GUARD+2).
- GUARD, 1: cycles at the start of each slot with all anodes inactive (anti-ghosting); 0 disables.
- BLINK_DIV, 500000: clk cycles per blink half-period.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp pins driven low to light.
- AN_ACTIVE_LOW, 1: 1 = an pins driven low to enable a digit.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: display enable.
- load, in, 1: capture strobe for the data inputs.
- bcd_in, in, 4*DIGITS: digit values; digit 0 = bits [3:0] = least significant.
- dp_in, in, DIGITS: decimal point per digit.
- blank_in, in, DIGITS: force digit dark.
- blink_in, in, DIGITS: digit dark during blink off-phase.
- lz_suppress, in, 1: enable leading-zero suppression (sampled live).
- seg, out, 7: segments {a,b,c,d,e,f,g}, bit 6 = a.
- dp, out, 1: decimal point pin.
- an, out, DIGITS: digit enables; bit i = digit i.
- scan_idx, out, clog2(DIGITS): digit currently driven.

Behaviour:
Reset (async, rst_n=0):
- Held data, dp, blank and blink registers = 0.
- Refresh counter = 0, scan_idx = 0, blink counter = 0, blink phase = 0 (on).
- All an inactive, seg and dp inactive: 7'h7F / 1 when active-low, 0 when active-high.

Capture:
- load=1 at a clk edge copies bcd_in, dp_in, blank_in and blink_in into the held registers.
- Inputs are ignored otherwise; the display uses held values only.

Scan:
- Refresh counter runs 0..REFRESH_DIV-1 while en=1.
- At the edge where the count = REFRESH_DIV-1, the counter wraps to 0 and scan_idx advances (DIGITS-1 wraps to 0).
- All outputs are registered: seg/dp/an reflect the new scan_idx one cycle after it changes.
- During refresh count 0..GUARD-1, all an are inactive and seg/dp keep the new digit's pattern.
- Otherwise exactly one an bit (scan_idx) is active.

Decode (active-high form, polarity applied last):
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

Dark digit:
- A digit is dark when any of these holds: blank bit set; blink bit set and blink phase=1; it is leading-zero suppressed.
- Dark means seg all inactive and dp inactive; the anode still follows the normal scan.

Leading-zero suppression (lz_suppress=1):
- Digit i is suppressed if its held value is 0 and every higher digit is 0 or blanked.
- Digit 0 is never suppressed, so "0000" shows "   0".
- dp_in on a suppressed digit is also suppressed.

Blink:
- Blink counter runs 0..BLINK_DIV-1 independently of en; blink phase toggles at each wrap.

en=0:
- All an inactive, seg/dp inactive.
- Refresh counter and scan_idx held at 0.
- When en returns to 1, the scan restarts at digit 0 with a full slot, including GUARD.

Simultaneous events:
- load in the same cycle as a slot change: the new digit is decoded from the newly loaded data, one cycle later.
- Reset mid-slot aborts immediately, with no partial output.

Test Plan:
Bench parameters: DIGITS=4, REFRESH_DIV=4, GUARD=1, BLINK_DIV=16, both polarities active-low.
- Reset: assert rst_n=0 mid-scan -> an=4'hF, seg=7'h7F and dp=1 immediately; scan_idx=0.
- Scan: load bcd_in=16'h1234, en=1 -> slot sequence an=F,E,E,E then F,D,D,D ...; during digit 0, seg=~7'b0110011 (4); during digit 3, seg=~7'b0110000 (1); wraps to digit 0 after digit 3.
- Hex: load 16'hABCD -> digit 0 shows ~0111101 (d) and digit 3 shows ~1110111 (A).
- Leading-zero suppression: load 16'h0050, lz_suppress=1 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Load 16'h0000 -> only digit 0 lit showing 0. With lz_suppress=0 -> all four digits show 0.
- Blink and blank: blink_in=4'b0001, blank_in=4'b0100 -> digit 0 dark for 16 cycles, lit for 16; digit 2 always dark; the an pattern is unchanged in both cases.
- en and load timing: drop en for 10 cycles mid-scan -> an=4'hF throughout; after re-enable, digit 0 gets a full 4-cycle slot. A load coincident with a slot change -> new value appears in that slot.
